// File: rtl/mod_addsub_pipe.sv
// Three-stage valid/ready modular adder/subtractor computing (a +/- b) mod P.
// Stage 1 forms propagate/generate, stage 2 resolves group carries, stage 3 corrects.
module mod_addsub_pipe #(
    parameter int                DATA_W = 64,
    parameter int                GRP_W  = 11,
    parameter logic [DATA_W-1:0] P      = 64'hFFFF_FFFF_0000_0001,
    parameter int                TAG_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sub,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_range_err
);
    localparam int NGRP  = 6;
    localparam int EXT_W = NGRP * GRP_W;
    localparam int PAD_W = EXT_W - DATA_W;

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic load1, load2, load3;

    logic [DATA_W-1:0] bEff;
    logic [DATA_W-1:0] p1_d, g1_d, p1_q, g1_q;
    logic [EXT_W-1:0]  pExt, gExt;
    logic [NGRP-1:0]   grpP1_d, grpG1_d, grpP1_q, grpG1_q;
    logic              err1_d, err1_q, sub1_q;
    logic [TAG_W-1:0]  tag1_q;

    logic [NGRP:0]     grpCarry;
    logic [DATA_W-1:0] sum2_d, diff2_d, sum2_q, diff2_q;
    logic              cout2_d, geP2_d, cout2_q, geP2_q;
    logic              sub2_q, err2_q;
    logic [TAG_W-1:0]  tag2_q;

    logic [DATA_W-1:0] res3_d, res3_q;
    logic [TAG_W-1:0]  tag3_q;
    logic              err3_q;

    always_comb begin
        load3 = !v3_q || out_ready;
        load2 = !v2_q || load3;
        load1 = !v1_q || load2;
        v1_d  = load1 ? in_valid : v1_q;
        v2_d  = load2 ? v1_q : v2_q;
        v3_d  = load3 ? v2_q : v3_q;
    end

    assign in_ready = rst_n && load1;

    always_comb begin
        bEff   = in_sub ? ~in_b : in_b;
        p1_d   = in_a ^ bEff;
        g1_d   = in_a & bEff;
        err1_d = (in_a >= P) || (in_b >= P);
    end

    // Padding bits propagate and never generate, so the top group acts at its real width.
    assign pExt = {{PAD_W{1'b1}}, p1_d};
    assign gExt = {{PAD_W{1'b0}}, g1_d};

    always_comb begin : groupPropGen
        logic gAcc;
        gAcc    = 1'b0;
        grpP1_d = '0;
        grpG1_d = '0;
        for (int k = 0; k < NGRP; k++) begin
            grpP1_d[k] = &pExt[k*GRP_W +: GRP_W];
            gAcc = 1'b0;
            for (int j = 0; j < GRP_W; j++) begin
                gAcc = gExt[k*GRP_W + j] | (pExt[k*GRP_W + j] & gAcc);
            end
            grpG1_d[k] = gAcc;
        end
    end

    always_comb begin : carryResolve
        logic c;
        c           = 1'b0;
        grpCarry    = '0;
        grpCarry[0] = sub1_q;
        for (int k = 0; k < NGRP; k++) begin
            grpCarry[k+1] = grpG1_q[k] | (grpP1_q[k] & grpCarry[k]);
        end
        sum2_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i % GRP_W == 0) begin
                c = grpCarry[i / GRP_W];
            end
            sum2_d[i] = p1_q[i] ^ c;
            c = g1_q[i] | (p1_q[i] & c);
        end
        cout2_d = grpCarry[NGRP];
        diff2_d = sum2_d + ~P + DATA_W'(1);
        geP2_d  = sum2_d >= P;
    end

    // A clear carry-out on subtraction is a borrow and needs P added back.
    always_comb begin
        res3_d = sum2_q;
        if (!sub2_q) begin
            if (cout2_q || geP2_q) begin
                res3_d = diff2_q;
            end
        end else if (!cout2_q) begin
            res3_d = sum2_q + P;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load1 && in_valid) begin
            p1_q    <= p1_d;
            g1_q    <= g1_d;
            grpP1_q <= grpP1_d;
            grpG1_q <= grpG1_d;
            err1_q  <= err1_d;
            sub1_q  <= in_sub;
            tag1_q  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (load2 && v1_q) begin
            sum2_q  <= sum2_d;
            diff2_q <= diff2_d;
            cout2_q <= cout2_d;
            geP2_q  <= geP2_d;
            sub2_q  <= sub1_q;
            err2_q  <= err1_q;
            tag2_q  <= tag1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res3_q <= '0;
            tag3_q <= '0;
            err3_q <= 1'b0;
        end else if (load3 && v2_q) begin
            res3_q <= res3_d;
            tag3_q <= tag2_q;
            err3_q <= err2_q;
        end
    end

    assign out_valid     = v3_q;
    assign out_res       = res3_q;
    assign out_tag       = tag3_q;
    assign out_range_err = err3_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: wrap/borrow vectors, range flag, backpressure,
// throughput and mid-stream reset, checked against hand values and a mod-P model.
module tb_mod_addsub_pipe;
    localparam int          DATA_W = 64;
    localparam int          TAG_W  = 14;
    localparam logic [63:0] PMOD   = 64'hFFFF_FFFF_0000_0001;

    typedef struct {
        logic [63:0] res;
        logic [13:0] tag;
        logic        err;
        int          accCycle;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sub;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_res;
    logic [TAG_W-1:0]  out_tag;
    logic              out_range_err;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycleNum    = 0;
    int          emitCount   = 0;
    int          emitBase    = 0;
    int          firstEmit   = -1;
    int          lastEmit    = -1;
    int          startCycle  = 0;
    int          sent        = 0;
    bit          checkLatency = 1'b0;
    bit          stalledPrev  = 1'b0;
    bit          lastAccepted = 1'b0;
    logic [63:0] heldRes;
    logic [13:0] heldTag;
    logic        heldErr;
    logic [63:0] curExpRes;
    logic        curExpErr;
    logic [63:0] curA, curB;
    logic        curSub;
    logic [13:0] curTag;
    beat_t       expQ[$];

    always #5 clk = ~clk;

    mod_addsub_pipe #(
        .DATA_W(DATA_W),
        .GRP_W (11),
        .P     (PMOD),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub       (in_sub),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_tag      (out_tag),
        .out_range_err(out_range_err)
    );

    function automatic logic [63:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                             input logic s);
        logic [64:0] w;
        if (!s) begin
            w = {1'b0, a} + {1'b0, b};
            if (w >= {1'b0, PMOD}) w = w - {1'b0, PMOD};
            return w[63:0];
        end
        if (a >= b) return a - b;
        return a - b + PMOD;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic [13:0] t, input logic ordy,
                                 input logic [63:0] expRes, input logic expErr);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = s;
        in_tag    = t;
        out_ready = ordy;
        curExpRes = expRes;
        curExpErr = expErr;
    endtask

    task automatic checkOutput();
        beat_t e;
        lastAccepted = 1'b0;
        if (stalledPrev) begin
            checkVal("holdValid", {63'd0, out_valid}, 64'd1);
            checkVal("holdRes", out_res, heldRes);
            checkVal("holdTag", {50'd0, out_tag}, {50'd0, heldTag});
            checkVal("holdErr", {63'd0, out_range_err}, {63'd0, heldErr});
        end
        checkVal("inReady", {63'd0, in_ready}, (expQ.size() < 3 || out_ready) ? 64'd1 : 64'd0);
        if (out_valid === 1'b1 && out_ready) begin
            emitCount++;
            if (firstEmit < 0) firstEmit = cycleNum;
            lastEmit = cycleNum;
            checkVal("emitExpected", (expQ.size() > 0) ? 64'd1 : 64'd0, 64'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkVal("res", out_res, e.res);
                checkVal("tag", {50'd0, out_tag}, {50'd0, e.tag});
                checkVal("rangeErr", {63'd0, out_range_err}, {63'd0, e.err});
                if (checkLatency) checkVal("latency", 64'(cycleNum - e.accCycle), 64'd3);
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            e.res      = curExpRes;
            e.tag      = in_tag;
            e.err      = curExpErr;
            e.accCycle = cycleNum;
            expQ.push_back(e);
            lastAccepted = 1'b1;
        end
        stalledPrev = (out_valid === 1'b1) && !out_ready;
        heldRes     = out_res;
        heldTag     = out_tag;
        heldErr     = out_range_err;
    endtask

    task automatic advance();
        #1 checkOutput();
        @(posedge clk);
        #1;
        cycleNum++;
    endtask

    task automatic newBeat(input int tagVal);
        curA   = {$urandom, $urandom} % PMOD;
        curB   = {$urandom, $urandom} % PMOD;
        curSub = 1'($urandom_range(0, 1));
        curTag = 14'(tagVal);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 14'd0, 1'b1, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        checkVal("rstInReady", {63'd0, in_ready}, 64'd0);
        checkVal("rstValid", {63'd0, out_valid}, 64'd0);
        checkVal("rstRes", out_res, 64'd0);
        checkVal("rstTag", {50'd0, out_tag}, 64'd0);
        checkVal("rstErr", {63'd0, out_range_err}, 64'd0);
        rst_n = 1'b1;
        #1;
        checkVal("postRstInReady", {63'd0, in_ready}, 64'd1);

        checkLatency = 1'b1;
        applyStimulus(1'b1, PMOD - 1, 64'd1, 1'b0, 14'd1, 1'b1, 64'd0, 1'b0);
        advance();
        applyStimulus(1'b1, PMOD - 1, PMOD - 1, 1'b0, 14'd2, 1'b1, 64'hFFFF_FFFE_FFFF_FFFF, 1'b0);
        advance();
        applyStimulus(1'b1, 64'd0, 64'd1, 1'b1, 14'd3, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0);
        advance();
        applyStimulus(1'b1, 64'd5, 64'd5, 1'b1, 14'd4, 1'b1, 64'd0, 1'b0);
        advance();
        applyStimulus(1'b1, 64'd7, 64'd3, 1'b1, 14'd5, 1'b1, 64'd4, 1'b0);
        advance();
        applyStimulus(1'b1, PMOD, 64'd0, 1'b0, 14'd6, 1'b1, 64'd0, 1'b1);
        advance();
        applyStimulus(1'b1, 64'd1, 64'd2, 1'b0, 14'd7, 1'b1, 64'd3, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 14'd0, 1'b1, 64'd0, 1'b0);
            advance();
        end
        checkVal("directedDrained", 64'(expQ.size()), 64'd0);

        checkLatency = 1'b0;
        sent         = 0;
        emitBase     = emitCount;
        newBeat(100);
        for (int i = 0; i < 200; i++) begin
            if (sent >= 10 && expQ.size() == 0) break;
            applyStimulus(sent < 10, curA, curB, curSub, curTag, (i % 3 == 0),
                          refModel(curA, curB, curSub), 1'b0);
            advance();
            if (lastAccepted) begin
                sent++;
                newBeat(100 + sent);
            end
        end
        checkVal("bpCount", 64'(emitCount - emitBase), 64'd10);

        checkLatency = 1'b1;
        firstEmit    = -1;
        emitBase     = emitCount;
        startCycle   = cycleNum;
        for (int i = 0; i < 20; i++) begin
            newBeat(200 + i);
            applyStimulus(1'b1, curA, curB, curSub, curTag, 1'b1,
                          refModel(curA, curB, curSub), 1'b0);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 14'd0, 1'b1, 64'd0, 1'b0);
            advance();
        end
        checkVal("tpCount", 64'(emitCount - emitBase), 64'd20);
        checkVal("tpFirst", 64'(firstEmit - startCycle), 64'd3);
        checkVal("tpSpan", 64'(lastEmit - firstEmit), 64'd19);

        checkLatency = 1'b0;
        for (int i = 0; i < 20 && expQ.size() < 3; i++) begin
            newBeat(300 + i);
            applyStimulus(1'b1, curA, curB, curSub, curTag, 1'b0,
                          refModel(curA, curB, curSub), 1'b0);
            advance();
        end
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 14'd0, 1'b0, 64'd0, 1'b0);
        #1;
        checkVal("fillCount", 64'(expQ.size()), 64'd3);
        checkVal("fillInReady", {63'd0, in_ready}, 64'd0);
        checkVal("fillOutValid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cycleNum++;
        checkVal("midRstValid", {63'd0, out_valid}, 64'd0);
        checkVal("midRstRes", out_res, 64'd0);
        checkVal("midRstTag", {50'd0, out_tag}, 64'd0);
        checkVal("midRstErr", {63'd0, out_range_err}, 64'd0);
        checkVal("midRstInReady", {63'd0, in_ready}, 64'd0);
        expQ.delete();
        stalledPrev = 1'b0;
        rst_n       = 1'b1;

        checkLatency = 1'b1;
        emitBase     = emitCount;
        applyStimulus(1'b1, 64'd10, 64'd20, 1'b0, 14'h2A, 1'b1, 64'd30, 1'b0);
        advance();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 14'd0, 1'b1, 64'd0, 1'b0);
            advance();
        end
        checkVal("postRstCount", 64'(emitCount - emitBase), 64'd1);
        checkVal("postRstQueue", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
